pipelined_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output. It splits a WIDTH-bit ripple-carry add into CHUNK-bit segments with a register after each segment. Latency is WIDTH/CHUNK cycles and throughput is one operation per cycle. It replaces the fixed 8-bit combinational ripple adder in datapaths that need wider operands, subtraction, overflow detection and back-pressure.

---
 rtl/pipelined_add_sub.sv | 133 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: pipelined two's-complement adder/subtractor with
// valid/ready handshakes. A WIDTH-bit ripple add is split into CHUNK-bit
// segments, one register stage per segment (latency WIDTH/CHUNK cycles,
// one operation per cycle). Optional signed saturation is enabled by
// defining PIPELINED_ADD_SUB_SAT_EN; otherwise the sum wraps.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   a, b, cin, sub      operands; sub=1 computes a-b, sub=0 computes a+b+cin
//   out_valid/out_ready output handshake
//   sum, cout, ovf      result, carry out of MSB, signed overflow
module pipelined_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  // Per-stage word: chunks already added hold result bits, the remaining
  // upper chunks still hold operand A. B is stored with sub already folded in.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  word_q  [STAGES];
  logic [WIDTH-1:0]  word_d  [STAGES];
  logic [WIDTH-1:0]  opb_q   [STAGES];
  logic [WIDTH-1:0]  opb_d   [STAGES];
  logic              carry_q [STAGES];
  logic              carry_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              advance;

  // Whole pipeline moves together; it only stalls when a held result is refused.
  assign advance   = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = word_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

  // One CHUNK-bit ripple segment per stage, fed by the previous stage's registers.
  always_comb begin
    logic [WIDTH-1:0] src_w;
    logic [WIDTH-1:0] src_b;
    logic             src_c;
    logic [CHUNK:0]   part;
    logic             msb_cin;
    int unsigned      prev;

    valid_d = '0;
    word_d  = '{default: '0};
    opb_d   = '{default: '0};
    carry_d = '{default: 1'b0};
    ovf_d   = 1'b0;
    src_w   = '0;
    src_b   = '0;
    src_c   = 1'b0;
    part    = '0;
    msb_cin = 1'b0;
    prev    = 0;

    for (int unsigned k = 0; k < STAGES; k++) begin
      prev = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        src_w      = a;
        src_b      = sub ? ~b : b;
        src_c      = sub | cin;
        valid_d[k] = in_valid;
      end else begin
        src_w      = word_q[prev];
        src_b      = opb_q[prev];
        src_c      = carry_q[prev];
        valid_d[k] = valid_q[prev];
      end

      part = (CHUNK+1)'(src_w[k*CHUNK +: CHUNK]) + (CHUNK+1)'(src_b[k*CHUNK +: CHUNK])
           + (CHUNK+1)'(src_c);

      word_d[k]                  = src_w;
      word_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      opb_d[k]                   = src_b;
      carry_d[k]                 = part[CHUNK];

      // Last segment: carry into the MSB recovered from the MSB sum bit.
      if (k == STAGES - 1) begin
        msb_cin = src_w[WIDTH-1] ^ src_b[WIDTH-1] ^ part[CHUNK-1];
        ovf_d   = msb_cin ^ part[CHUNK];
`ifdef PIPELINED_ADD_SUB_SAT_EN
        // Clamp toward the sign of A; flags still report the raw condition.
        if (ovf_d) begin
          word_d[k] = src_w[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        word_q[k]  <= '0;
        opb_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        word_q[k]  <= word_d[k];
        opb_q[k]   <= opb_d[k];
        carry_q[k] <= carry_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: scoreboard bench for pipelined_add_sub
// (16/4 instance for the main sequence, 8/8 instance for the single-stage case).
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        v8, ir8, c8in, sub8, ov8, or8, co8, of8;
  logic [7:0]  a8, b8, s8;

  int errors   = 0;
  int checks   = 0;
  int received = 0;
  logic [17:0] sbq[$];

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(c8in), .sub(sub8), .out_valid(ov8),
    .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width add, overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] bp;
    logic [16:0] full;
    logic        o;
    bp   = ms ? ~mb : mb;
    full = 17'(ma) + 17'(bp) + 17'(ms ? 1'b1 : mc);
    o    = (ma[15] == bp[15]) && (full[15] != ma[15]);
`ifdef PIPELINED_ADD_SUB_SAT_EN
    if (o) full[15:0] = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, full};
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("sb_sum", 32'(sum), 32'(e[15:0]));
        check("sb_cout", 32'(cout), 32'(e[16]));
        check("sb_ovf", 32'(ovf), 32'(e[17]));
        received++;
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(model(ta, tb_, tc, ts));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 64; n++) begin
      if (out_valid) return;
      @(posedge clk); #1;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (sbq.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int          i;
    int          stall_left;
    int          low;
    int          rec0;
    bit          stalled;
    logic [18:0] held;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; c8in = 1'b0; sub8 = 1'b0; or8 = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid8", 32'(ov8), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 0xFFFF + 1: latency 4, carry out, no overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check("t1_latency", 32'(out_valid), 32'(k == 3));
    end
    check("t1_sum", 32'(sum), 32'h0000);
    check("t1_cout", 32'(cout), 32'd1);
    check("t1_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    check("t1_gone", 32'(out_valid), 32'd0);

    // Subtraction with borrow, then signed overflow on subtract
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_valid("t2_timeout");
    check("t2a_sum", 32'(sum), 32'hFFFE);
    check("t2a_cout", 32'(cout), 32'd0);
    check("t2a_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
`ifdef PIPELINED_ADD_SUB_SAT_EN
    check("t2b_sum", 32'(sum), 32'h8000);
`else
    check("t2b_sum", 32'(sum), 32'h7FFF);
`endif
    check("t2b_cout", 32'(cout), 32'd1);
    check("t2b_ovf", 32'(ovf), 32'd1);
    drain();

    // Positive overflow on add
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_valid("t3_timeout");
`ifdef PIPELINED_ADD_SUB_SAT_EN
    check("t3_sum", 32'(sum), 32'h7FFF);
`else
    check("t3_sum", 32'(sum), 32'h8000);
`endif
    check("t3_cout", 32'(cout), 32'd0);
    check("t3_ovf", 32'(ovf), 32'd1);
    drain();

    // Back-to-back burst with a 3-cycle stall starting at the first result
    i = 0; stall_left = 3; stalled = 1'b0; low = 0; rec0 = received; held = '0;
    for (int cyc = 0; cyc < 60 && (i < 8 || sbq.size() > 0); cyc++) begin
      in_valid = (i < 8); a = 16'(i); b = 16'h0100; cin = 1'b0; sub = 1'b0;
      if (out_valid && !stalled) stalled = 1'b1;
      if (stalled && stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      check("t4_in_ready", 32'(in_ready), 32'(out_ready));
      if (!in_ready) low++;
      if (!out_ready) begin
        if (stall_left == 2) held = {out_valid, ovf, cout, sum};
        else check("t4_hold", 32'({out_valid, ovf, cout, sum}), 32'(held));
      end
      if (in_valid && in_ready) begin
        sbq.push_back(model(16'(i), 16'h0100, 1'b0, 1'b0));
        i++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t4_held_valid", 32'(held[18]), 32'd1);
    check("t4_stall_cycles", 32'(low), 32'd3);
    check("t4_accepted", 32'(i), 32'd8);
    check("t4_received", 32'(received - rec0), 32'd8);
    drain();

    // Random traffic with random back-pressure
    for (int cyc = 0; cyc < 80; cyc++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) sbq.push_back(model(a, b, cin, sub));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset while a result is being held
    out_ready = 1'b0;
    send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    wait_valid("r1_timeout");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("r1_out_valid", 32'(out_valid), 32'd0);
    check("r1_sum", 32'(sum), 32'd0);
    check("r1_cout", 32'(cout), 32'd0);
    check("r1_ovf", 32'(ovf), 32'd0);
    check("r1_in_ready", 32'(in_ready), 32'd1);
    sbq.delete();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset with three operations in flight, none may reappear
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0);
    send(16'h5555, 16'h0001, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("r2_out_valid", 32'(out_valid), 32'd0);
    check("r2_sum", 32'(sum), 32'd0);
    sbq.delete();
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("r2_quiet", 32'(out_valid), 32'd0);
    end

    // Single-stage 8-bit instance
    v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8in = 1'b1; sub8 = 1'b0;
    check("t6_pre_valid", 32'(ov8), 32'd0);
    check("t6_in_ready", 32'(ir8), 32'd1);
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20; c8in = 1'b0; sub8 = 1'b1;
    check("t6_valid", 32'(ov8), 32'd1);
    check("t6_sum", 32'(s8), 32'h00);
    check("t6_cout", 32'(co8), 32'd1);
    check("t6_ovf", 32'(of8), 32'd0);
    @(posedge clk); #1;
    v8 = 1'b0;
    check("t6b_sum", 32'(s8), 32'hF0);
    check("t6b_cout", 32'(co8), 32'd0);
    check("t6b_ovf", 32'(of8), 32'd0);
    @(posedge clk); #1;
    check("t6_empty", 32'(ov8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
